tdc_fifo_arbiter: RTL and testbench
===================================

Name: tdc_fifo_arbiter

Overview:
- Shares the single FIFO write path between N_REQ TDC-style event sources.
- Each source raises a level request carrying a 3-byte word. The arbiter picks one source round-robin, latches its word and pulses the FIFO writer to start.
- It waits for f_FIFO_writing_done, acknowledges the winning source, then enforces a minimum idle gap before the next grant.
- Sits between the TDC front-ends and the FIFO writer; replaces direct wr_en wiring.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TMO_W, 16, width of the done-timeout counter.
- TIMEOUT, 50000, cycles to wait for f_FIFO_writing_done before aborting (1..2^TMO_W-1).
- GAP, 4, idle cycles enforced after each transaction (0..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- req  in  N_REQ  level request per source; held until ack.
- req_data  in  24*N_REQ  3-byte payload per source; source i occupies bits [24i+23:24i].
- f_FIFO_writing_done  in  1  one-cycle pulse from FIFO writer when the word is written.
- wr_start  out  1  one-cycle pulse to FIFO writer.
- wr_data  out  24  latched payload of the granted source.
- grant  out  N_REQ  one-hot owner of the FIFO path; all-zero when none.
- ack  out  N_REQ  one-cycle completion pulse to the owning source.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge) gives: state IDLE; grant=0, ack=0, wr_start=0, wr_data=0, busy=0, timeout_err=0; pointer=N_REQ-1, so source 0 has first priority.
- Reset applied mid-transaction aborts immediately, with no ack and no wr_start.
- States: IDLE, START, WAIT_DONE, RELEASE, GAP.
- IDLE:
  - If req≠0, choose the first asserted bit searching upward from pointer+1 with wrap at N_REQ.
  - Latch its index and req_data into wr_data, then go to START.
  - Request sampled at edge t gives grant and wr_start high in cycle t+1.
- START:
  - wr_start=1 for exactly this cycle; grant held.
  - Clear the timer, then go to WAIT_DONE.
- WAIT_DONE:
  - f_FIFO_writing_done=1 → RELEASE.
  - Otherwise, if timer==TIMEOUT-1: set timeout_err, clear grant and go to GAP with no ack.
  - Otherwise increment the timer.
- RELEASE:
  - ack[idx]=1 for this cycle only; grant still high.
  - Next cycle grant=0. Go to GAP, or to IDLE if GAP=0.
- GAP:
  - Count GAP cycles with grant=0, then go to IDLE.
- Pointer update: pointer←idx on both RELEASE and timeout abort, so a stuck source cannot starve the others.
- f_FIFO_writing_done outside WAIT_DONE is ignored, including in the START cycle.
- req is sampled only in IDLE.
  - A source dropping req while granted does not cancel the transaction; wr_data stays latched.
  - A source that keeps req high after ack is re-granted only after every other pending source has had its turn.
- wr_data is stable from START until the next IDLE→START transition.
- Grant remains one-hot or zero at all times.
- Minimum transaction length is 4 cycles plus GAP: START, one WAIT_DONE cycle, RELEASE, exit.
- timeout_err is cleared only by reset.

Test Plan:
- Single source: req=4'b0001, data 0xA1B2C3, done 3 cycles after wr_start → grant=0001 from cycle 1, wr_start in cycle 1, wr_data=0xA1B2C3, ack[0] one cycle after done, grant=0 next cycle, busy low after 4 GAP cycles.
- All four req held high, done returned 2 cycles after each wr_start → grants in order 0001, 0010, 0100, 1000, 0001; acks match; ≥4 idle cycles between grant pulses.
- Timeout: TIMEOUT=10, done never arrives → timeout_err=1 after 10 WAIT_DONE cycles, no ack, grant cleared; next pending source (req=0011, owner 0) is granted after the gap.
- Spurious done during IDLE and during the START cycle → ignored. The transaction completes only on a done inside WAIT_DONE.
- Reset (rst=0 for 1 cycle) in WAIT_DONE → all outputs zero next cycle, timeout_err cleared, next grant goes to source 0 when req=1111.
- Requester 2 drops req while granted → transaction still completes, ack[2] pulses, wr_data unchanged throughout.

Source files
------------

// File: rtl/tdc_fifo_arbiter_if.sv
// Request/response bundle between TDC front-ends, the arbiter and the FIFO writer.
// The arbiter takes the slave side; the environment (front-ends plus writer) takes the master side.
interface tdc_fifo_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [24*N_REQ-1:0] req_data;
  logic                f_FIFO_writing_done;
  logic                wr_start;
  logic [23:0]         wr_data;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    ack;
  logic                busy;
  logic                timeout_err;

  modport master (
    output req, req_data, f_FIFO_writing_done,
    input  wr_start, wr_data, grant, ack, busy, timeout_err
  );

  modport slave (
    input  req, req_data, f_FIFO_writing_done,
    output wr_start, wr_data, grant, ack, busy, timeout_err
  );
endinterface

// File: rtl/tdc_fifo_arbiter.sv
// Round-robin owner of the shared FIFO write path: grant, start pulse, wait for done
// (with abort on timeout), acknowledge, then hold off for a fixed idle gap.
module tdc_fifo_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 50000,
  parameter int GAP     = 4
) (
  input  logic              clk,
  input  logic              rst,
  tdc_fifo_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_RELEASE,
    S_GAP
  } state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [TMO_W-1:0] r_timer;
  logic [7:0]       r_gap_cnt;
  logic             r_wr_start;
  logic [23:0]      r_wr_data;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_ack;
  logic             r_busy;
  logic             r_timeout_err;

  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic [23:0]      w_pick_data;

  // Search upward from the slot after the last owner, wrapping at N_REQ.
  always_comb begin
    int j;
    // NOTE: every combinational output is given a default before the loop, so no path leaves it unassigned and no latch is inferred.
    j          = 0;
    w_found    = 1'b0;
    w_pick_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_found && bus.req[j]) begin
        w_found    = 1'b1;
        w_pick_idx = IDX_W'(j);
      end
    end
  end

  assign w_pick_data = bus.req_data[24*int'(w_pick_idx) +: 24];

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= IDX_W'(N_REQ - 1);
      r_idx         <= '0;
      r_timer       <= '0;
      r_gap_cnt     <= '0;
      r_wr_start    <= 1'b0;
      r_wr_data     <= '0;
      r_grant       <= '0;
      r_ack         <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wr_start <= 1'b0;
      r_ack      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_START;
            r_idx      <= w_pick_idx;
            r_wr_data  <= w_pick_data;
            r_grant    <= N_REQ'(1) << w_pick_idx;
            r_wr_start <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.f_FIFO_writing_done) begin
            r_state <= S_RELEASE;
            r_ack   <= N_REQ'(1) << r_idx;
          end else if (r_timer == TMO_W'(TIMEOUT - 1)) begin
            // Abort: the stuck owner moves to lowest priority just like a completed one.
            r_timeout_err <= 1'b1;
            r_grant       <= '0;
            r_ptr         <= r_idx;
            r_gap_cnt     <= '0;
            if (GAP == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_timer <= r_timer + TMO_W'(1);
          end
        end
        S_RELEASE: begin
          r_grant   <= '0;
          r_ptr     <= r_idx;
          r_gap_cnt <= '0;
          if (GAP == 0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 8'(GAP - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_start    = r_wr_start;
  assign bus.wr_data     = r_wr_data;
  assign bus.grant       = r_grant;
  assign bus.ack         = r_ack;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tdc_fifo_arbiter.sv
// Scoreboard bench for tdc_fifo_arbiter: the driver predicts each winner from a round-robin
// model and queues expected grants/outcomes; an independent monitor compares DUT outputs.
module tb_tdc_fifo_arbiter;
  localparam int N    = 4;
  localparam int TMO  = 10;
  localparam int GAPC = 4;

  typedef struct {
    logic [N-1:0] grant;
    logic [23:0]  data;
  } start_t;

  typedef struct {
    bit           is_tmo;
    logic [N-1:0] vec;
  } event_t;

  logic clk = 1'b0;
  logic rst;

  tdc_fifo_arbiter_if #(.N_REQ(N)) bus ();

  tdc_fifo_arbiter #(
    .N_REQ  (N),
    .TMO_W  (16),
    .TIMEOUT(TMO),
    .GAP    (GAPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     mon_skip = 2;
  int     model_ptr = N - 1;
  start_t exp_start[$];
  event_t exp_ev[$];
  logic [23:0] lane[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: first requester strictly after the last owner, with wrap.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (model_ptr + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.req_data[24*i +: 24] = lane[i];
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) lane[i] = 24'($urandom);
    drive_data();
  endtask

  // One transaction: dly<0 means done never arrives; spur raises done in the START cycle;
  // drop withdraws the winner's request and scrambles its payload once granted.
  task automatic run_txn(input logic [N-1:0] reqv, input int dly, input bit spur, input bit drop);
    int w;
    bit seen;
    w = model_pick(reqv);
    exp_start.push_back('{grant: N'(1) << w, data: lane[w]});
    bus.req = reqv;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.wr_start;
    end
    check("wr_start_seen", 32'(seen), 32'd1);
    if (!seen) begin
      model_ptr = w;
      return;
    end
    if (drop) begin
      bus.req[w] = 1'b0;
      lane[w] = ~lane[w];
      drive_data();
    end
    if (spur) bus.f_FIFO_writing_done = 1'b1;
    if (dly < 0) begin
      exp_ev.push_back('{is_tmo: 1'b1, vec: '0});
      @(negedge clk);
      bus.f_FIFO_writing_done = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < TMO + 10 && !seen; c++) begin
        @(negedge clk);
        seen = (bus.grant == '0);
      end
      check("abort_seen", 32'(seen), 32'd1);
    end else begin
      for (int k = 1; k <= dly; k++) begin
        @(negedge clk);
        bus.f_FIFO_writing_done = 1'b0;
      end
      exp_ev.push_back('{is_tmo: 1'b0, vec: N'(1) << w});
      bus.f_FIFO_writing_done = 1'b1;
      @(negedge clk);
      bus.f_FIFO_writing_done = 1'b0;
    end
    model_ptr = w;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start, an ack or an abort.
  initial begin : monitor
    logic [N-1:0] prev_grant;
    logic [N-1:0] prev_ack;
    logic [23:0]  cur_data;
    bit           have_data;
    bit           first;
    int           zero_cnt;
    start_t       s;
    event_t       e;
    prev_grant = '0;
    prev_ack   = '0;
    cur_data   = '0;
    have_data  = 1'b0;
    first      = 1'b1;
    zero_cnt   = 0;
    forever begin
      @(negedge clk);
      if (mon_skip > 0) begin
        mon_skip--;
        have_data = 1'b0;
        first     = 1'b1;
        zero_cnt  = 0;
      end else begin
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        if (bus.wr_start) begin
          if (exp_start.size() == 0) begin
            check("wr_start_unexpected", 32'(bus.wr_start), 32'd0);
          end else begin
            s = exp_start.pop_front();
            check("grant_on_start", 32'(bus.grant), 32'(s.grant));
            check("wr_data_on_start", 32'(bus.wr_data), 32'(s.data));
            cur_data  = s.data;
            have_data = 1'b1;
          end
        end else if (bus.grant != '0 && have_data) begin
          check("wr_data_stable", 32'(bus.wr_data), 32'(cur_data));
        end
        if (prev_grant == '0 && bus.grant != '0) begin
          if (!first) check("idle_gap_ge_GAP", 32'(zero_cnt >= GAPC), 32'd1);
          first = 1'b0;
        end
        if (bus.grant == '0) zero_cnt++;
        else zero_cnt = 0;
        if (bus.ack != '0) begin
          if (exp_ev.size() == 0) begin
            check("ack_unexpected", 32'(bus.ack), 32'd0);
          end else begin
            e = exp_ev.pop_front();
            check("ack_not_timeout", 32'(e.is_tmo), 32'd0);
            check("ack_vector", 32'(bus.ack), 32'(e.vec));
            check("grant_held_on_ack", 32'(bus.grant), 32'(e.vec));
          end
        end else if (prev_grant != '0 && bus.grant == '0 && prev_ack == '0) begin
          if (exp_ev.size() == 0) begin
            check("grant_drop_unexpected", 32'(prev_grant), 32'd0);
          end else begin
            e = exp_ev.pop_front();
            check("abort_expected", 32'(e.is_tmo), 32'd1);
            check("timeout_err_on_abort", 32'(bus.timeout_err), 32'd1);
          end
        end
      end
      prev_grant = bus.grant;
      prev_ack   = bus.ack;
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int dly;
    bit spur;
    bit drop;
    logic [N-1:0] rv;
    rst = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.f_FIFO_writing_done = 1'b0;
    for (int i = 0; i < N; i++) lane[i] = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_wr_start", 32'(bus.wr_start), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Timeout on owner 0, then the other pending source wins after the gap.
    rand_data();
    run_txn(4'b0011, -1, 1'b0, 1'b0);
    check("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
    run_txn(4'b0011, 2, 1'b0, 1'b0);

    // Single source with a fixed payload; busy falls only after the gap.
    rand_data();
    lane[0] = 24'hA1B2C3;
    drive_data();
    run_txn(4'b0001, 3, 1'b0, 1'b0);
    bus.req = '0;
    for (int i = 0; i < GAPC; i++) begin
      @(negedge clk);
      check("busy_during_gap", 32'(bus.busy), 32'd1);
      check("grant_zero_in_gap", 32'(bus.grant), 32'd0);
    end
    @(negedge clk);
    check("busy_low_after_gap", 32'(bus.busy), 32'd0);

    // Spurious done while idle, then again in the START cycle.
    bus.f_FIFO_writing_done = 1'b1;
    @(negedge clk);
    bus.f_FIFO_writing_done = 1'b0;
    @(negedge clk);
    check("idle_done_ignored_busy", 32'(bus.busy), 32'd0);
    rand_data();
    run_txn(4'b0010, 3, 1'b1, 1'b0);

    // Requester 2 withdraws while granted.
    rand_data();
    run_txn(4'b0100, 3, 1'b0, 1'b1);

    // Reset in WAIT_DONE aborts with all outputs cleared.
    rand_data();
    bus.req = 4'b1111;
    exp_start.push_back('{grant: N'(1) << model_pick(4'b1111), data: lane[model_pick(4'b1111)]});
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = bus.wr_start;
      end
      check("wr_start_before_reset", 32'(seen), 32'd1);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    mon_skip = 2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("midrst_grant", 32'(bus.grant), 32'd0);
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_wr_start", 32'(bus.wr_start), 32'd0);
    check("midrst_wr_data", 32'(bus.wr_data), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_timeout_err", 32'(bus.timeout_err), 32'd0);
    rst = 1'b1;
    model_ptr = N - 1;

    // All four held: strict rotation starting at source 0.
    for (int t = 0; t < 5; t++) begin
      rand_data();
      run_txn(4'b1111, 2, 1'b0, 1'b0);
    end

    // Randomised mix of request sets, latencies, spurious dones, drops and timeouts.
    for (int t = 0; t < 30; t++) begin
      rand_data();
      rv   = N'($urandom_range(1, (1 << N) - 1));
      dly  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 5));
      spur = ($urandom_range(0, 3) == 0);
      drop = ($urandom_range(0, 4) == 0);
      run_txn(rv, dly, spur, drop);
    end

    bus.req = '0;
    repeat (12) @(negedge clk);
    check("final_busy", 32'(bus.busy), 32'd0);
    check("start_queue_empty", 32'(exp_start.size()), 32'd0);
    check("event_queue_empty", 32'(exp_ev.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
